move_list_sequencer: RTL
========================

MOVE_LIST_SEQUENCER -- requirements
Module: move_list_sequencer

Interface
REQ-001 Parameters SHALL be: MAX_POSITIONS_LOG2 (default 8), move index width; EVAL_WIDTH (24), signed eval width; UCI_WIDTH (16), {promotion, to, from} word width; RD_LATENCY (5, legal range 1..15), cycles from index change to valid move data.
REQ-002 clk, input, 1: sole clock; all logic on rising edge.
REQ-003 reset_n, input, 1: asynchronous active-low reset.
REQ-004 start, input, 1: one-cycle request to drain the current move list.
REQ-005 mode_best, input, 1: sampled at start; 0 = stream every move, 1 = emit only the best move.
REQ-006 am_moves_ready / am_idle, inputs, 1 each: move generator handshake.
REQ-007 am_move_count, input, MAX_POSITIONS_LOG2: number of generated moves.
REQ-008 initial_mate / initial_stalemate / initial_thrice_rep, inputs, 1 each: terminal flags of the root position.
REQ-009 white_to_move, input, 1: sampled at start; selects the sign used for best-move selection.
REQ-010 uci_in, input, UCI_WIDTH, and eval_in, input, EVAL_WIDTH signed: data for the addressed move.
REQ-011 am_move_index, output, MAX_POSITIONS_LOG2: read address into the move RAM.
REQ-012 am_clear_moves, output, 1: one-cycle pulse that releases the generator.
REQ-013 out_valid, output, 1 / out_ready, input, 1: output stream handshake.
REQ-014 out_index (MAX_POSITIONS_LOG2), out_uci (UCI_WIDTH), out_eval (EVAL_WIDTH), out_last (1), outputs: stream payload.
REQ-015 done, output, 1: one-cycle completion pulse. status, output, 2: 0 normal, 1 checkmate, 2 stalemate, 3 repetition with zero moves. busy, output, 1: high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, WAIT_GEN, RD_WAIT, CAPTURE, EMIT, TERMINAL, CLEAR, CLEAR_WAIT.
REQ-017 IDLE: start moves to WAIT_GEN; start is ignored in any other state.
REQ-018 WAIT_GEN: am_moves_ready moves to TERMINAL if am_move_count==0, else to RD_WAIT with index 0; count is latched at this point.
REQ-019 RD_WAIT: a counter runs from 0 to RD_LATENCY-1, then the state moves to CAPTURE; am_move_index is held stable for the whole wait.
REQ-020 CAPTURE: uci_in and eval_in are registered. Stream mode goes to EMIT. Best mode updates the best record, then advances the index or goes to EMIT after the last move.
REQ-021 Best record: key = eval if white to move, else -eval, computed at EVAL_WIDTH+1 bits to avoid overflow on the most negative value. Update only on key > best key; ties keep the lowest index. The first move always loads the record.
REQ-022 EMIT: out_valid held high with a stable payload until out_ready; a transfer happens on the cycle where out_valid and out_ready are both high.
REQ-023 out_last is high only on the final transfer: index count-1 in stream mode; always in best mode, which makes exactly one transfer.
REQ-024 After a stream-mode transfer that is not the last, the index increments and the state returns to RD_WAIT. The last transfer goes to CLEAR.
REQ-025 TERMINAL: status is set by priority mate > stalemate > repetition > normal; no transfer occurs; the state goes to CLEAR.
REQ-026 CLEAR: am_clear_moves is pulsed for exactly one cycle, then CLEAR_WAIT.
REQ-027 CLEAR_WAIT: waits until am_moves_ready is low and am_idle is high, then pulses done and returns to IDLE.
REQ-028 Count == 2^MAX_POSITIONS_LOG2-1 SHALL complete without index wrap; the index never exceeds count-1.
REQ-029 Status SHALL be held from done until the next start.

Reset
REQ-030 While reset_n is low the block SHALL be in IDLE; am_move_index, am_clear_moves, out_valid, out_*, done, busy and status are all 0, and the counter and best record are cleared.
REQ-031 Reset asserted mid-operation SHALL abort immediately with no done and no am_clear_moves; the generator is then released by its own reset.

Structure
REQ-032 State encodings and status codes SHALL live in the shared package/header next to the existing move and board constants.
REQ-033 One sub-module, move_best_select, SHALL hold the signed key compare and best register.

Verification
REQ-034 Stream mode, count=3, RD_LATENCY=5, out_ready tied high -> three transfers, indices 0,1,2, out_last on index 2, each index stable at least 5 cycles, one am_clear_moves, one done.
REQ-035 Best mode, white to move, evals {10,-40,35,35} -> one transfer, index 2, out_eval 35, out_last=1.
REQ-036 Best mode, black to move, evals {10,-40,-8388608} -> index 2 selected, with no overflow.
REQ-037 Count=0 with initial_mate=1 and initial_stalemate=1 -> status=1, no out_valid, am_clear_moves pulsed, done.
REQ-038 Stream mode, out_ready low for 7 cycles during transfer 1 -> payload stable throughout, no duplicate and no drop.
REQ-039 reset_n low during RD_WAIT of index 1 -> all outputs 0 asynchronously; a new start after release completes normally.

Source files
------------

// File: rtl/move_list_sequencer_pkg.sv
// Shared move/board constants plus the sequencer state and status encodings.
package move_list_sequencer_pkg;

    localparam int SQ_BITS    = 6;
    localparam int PROMO_BITS = 4;
    localparam int UCI_BITS   = PROMO_BITS + 2 * SQ_BITS;
    localparam int LAT_CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_GEN   = 3'd1,
        ST_RD_WAIT    = 3'd2,
        ST_CAPTURE    = 3'd3,
        ST_EMIT       = 3'd4,
        ST_TERMINAL   = 3'd5,
        ST_CLEAR      = 3'd6,
        ST_CLEAR_WAIT = 3'd7
    } seq_state_t;

    typedef enum logic [1:0] {
        STATUS_NORMAL     = 2'd0,
        STATUS_MATE       = 2'd1,
        STATUS_STALEMATE  = 2'd2,
        STATUS_REPETITION = 2'd3
    } seq_status_t;

    function automatic seq_status_t terminal_status(input logic mate, input logic stalemate,
                                                    input logic rep);
        if (mate)           return STATUS_MATE;
        else if (stalemate) return STATUS_STALEMATE;
        else if (rep)       return STATUS_REPETITION;
        else                return STATUS_NORMAL;
    endfunction

endpackage

// File: rtl/move_list_sequencer_best_select.sv
// Best-move record: side-relative signed key compare; ties keep the earlier index.
module move_best_select #(
    parameter int IDX_W  = 8,
    parameter int EVAL_W = 24,
    parameter int UCI_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_clear,
    input  logic                     i_load,
    input  logic                     i_first,
    input  logic                     i_white_to_move,
    input  logic [IDX_W-1:0]         i_index,
    input  logic [UCI_W-1:0]         i_uci,
    input  logic signed [EVAL_W-1:0] i_eval,
    output logic [IDX_W-1:0]         o_best_index,
    output logic [UCI_W-1:0]         o_best_uci,
    output logic signed [EVAL_W-1:0] o_best_eval
);

    logic signed [EVAL_W:0] w_ext;
    logic signed [EVAL_W:0] w_key;
    logic                   w_better;
    logic signed [EVAL_W:0] r_key;
    logic [IDX_W-1:0]       r_index;
    logic [UCI_W-1:0]       r_uci;
    logic signed [EVAL_W-1:0] r_eval;

    // One extra bit so negating the most negative eval cannot overflow.
    assign w_ext    = {i_eval[EVAL_W-1], i_eval};
    assign w_key    = i_white_to_move ? w_ext : -w_ext;
    assign w_better = i_first || (w_key > r_key);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key   <= '0;
            r_index <= '0;
            r_uci   <= '0;
            r_eval  <= '0;
        end else if (i_clear) begin
            r_key   <= '0;
            r_index <= '0;
            r_uci   <= '0;
            r_eval  <= '0;
        end else if (i_load && w_better) begin
            r_key   <= w_key;
            r_index <= i_index;
            r_uci   <= i_uci;
            r_eval  <= i_eval;
        end
    end

    assign o_best_index = r_index;
    assign o_best_uci   = r_uci;
    assign o_best_eval  = r_eval;

endmodule

// File: rtl/move_list_sequencer.sv
// Drains the generated move list, either streaming every move or emitting only the best,
// and reports root terminal status when there are no moves.
module move_list_sequencer
    import move_list_sequencer_pkg::*;
#(
    parameter int MAX_POSITIONS_LOG2 = 8,
    parameter int EVAL_WIDTH         = 24,
    parameter int UCI_WIDTH          = UCI_BITS,
    parameter int RD_LATENCY         = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          mode_best,
    input  logic                          am_moves_ready,
    input  logic                          am_idle,
    input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
    input  logic                          initial_mate,
    input  logic                          initial_stalemate,
    input  logic                          initial_thrice_rep,
    input  logic                          white_to_move,
    input  logic [UCI_WIDTH-1:0]          uci_in,
    input  logic signed [EVAL_WIDTH-1:0]  eval_in,
    output logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
    output logic                          am_clear_moves,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_POSITIONS_LOG2-1:0] out_index,
    output logic [UCI_WIDTH-1:0]          out_uci,
    output logic signed [EVAL_WIDTH-1:0]  out_eval,
    output logic                          out_last,
    output logic                          done,
    output logic [1:0]                    status,
    output logic                          busy
);

    localparam int IDX_W = MAX_POSITIONS_LOG2;
    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(RD_LATENCY - 1);

    seq_state_t               r_state, w_state_nxt;
    seq_status_t              r_status, w_status_nxt;
    logic [IDX_W-1:0]         r_index, w_index_nxt;
    logic [IDX_W-1:0]         r_count, w_count_nxt;
    logic [LAT_CNT_W-1:0]     r_lat_cnt, w_lat_nxt;
    logic                     r_mode_best, w_mode_nxt;
    logic                     r_wtm, w_wtm_nxt;
    logic [UCI_WIDTH-1:0]     r_uci, w_uci_nxt;
    logic signed [EVAL_WIDTH-1:0] r_eval, w_eval_nxt;
    logic                     r_done, w_done_nxt;
    logic                     w_best_clear, w_best_load, w_is_last;
    logic [IDX_W-1:0]         w_best_index;
    logic [UCI_WIDTH-1:0]     w_best_uci;
    logic signed [EVAL_WIDTH-1:0] w_best_eval;

    // Count is at least 1 whenever this is consulted, so no underflow.
    assign w_is_last = (r_index == r_count - IDX_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_status    <= STATUS_NORMAL;
            r_index     <= '0;
            r_count     <= '0;
            r_lat_cnt   <= '0;
            r_mode_best <= 1'b0;
            r_wtm       <= 1'b0;
            r_uci       <= '0;
            r_eval      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_status    <= w_status_nxt;
            r_index     <= w_index_nxt;
            r_count     <= w_count_nxt;
            r_lat_cnt   <= w_lat_nxt;
            r_mode_best <= w_mode_nxt;
            r_wtm       <= w_wtm_nxt;
            r_uci       <= w_uci_nxt;
            r_eval      <= w_eval_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_index_nxt  = r_index;
        w_count_nxt  = r_count;
        w_lat_nxt    = r_lat_cnt;
        w_mode_nxt   = r_mode_best;
        w_wtm_nxt    = r_wtm;
        w_uci_nxt    = r_uci;
        w_eval_nxt   = r_eval;
        w_done_nxt   = 1'b0;
        w_best_clear = 1'b0;
        w_best_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_WAIT_GEN;
                    w_mode_nxt   = mode_best;
                    w_wtm_nxt    = white_to_move;
                    w_status_nxt = STATUS_NORMAL;
                    w_best_clear = 1'b1;
                end
            end
            ST_WAIT_GEN: begin
                if (am_moves_ready) begin
                    w_count_nxt = am_move_count;
                    w_index_nxt = '0;
                    w_lat_nxt   = '0;
                    w_state_nxt = (am_move_count == '0) ? ST_TERMINAL : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (r_lat_cnt == LAT_LAST) w_state_nxt = ST_CAPTURE;
                else                       w_lat_nxt   = r_lat_cnt + LAT_CNT_W'(1);
            end
            ST_CAPTURE: begin
                w_uci_nxt  = uci_in;
                w_eval_nxt = eval_in;
                if (!r_mode_best) begin
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_best_load = 1'b1;
                    if (w_is_last) begin
                        w_state_nxt = ST_EMIT;
                    end else begin
                        w_index_nxt = r_index + IDX_W'(1);
                        w_lat_nxt   = '0;
                        w_state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (r_mode_best || w_is_last) begin
                        w_state_nxt = ST_CLEAR;
                    end else begin
                        w_index_nxt = r_index + IDX_W'(1);
                        w_lat_nxt   = '0;
                        w_state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_TERMINAL: begin
                w_status_nxt = terminal_status(initial_mate, initial_stalemate, initial_thrice_rep);
                w_state_nxt  = ST_CLEAR;
            end
            ST_CLEAR: w_state_nxt = ST_CLEAR_WAIT;
            ST_CLEAR_WAIT: begin
                if (!am_moves_ready && am_idle) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    move_best_select #(
        .IDX_W  (IDX_W),
        .EVAL_W (EVAL_WIDTH),
        .UCI_W  (UCI_WIDTH)
    ) u_best (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_clear         (w_best_clear),
        .i_load          (w_best_load),
        .i_first         (r_index == '0),
        .i_white_to_move (r_wtm),
        .i_index         (r_index),
        .i_uci           (uci_in),
        .i_eval          (eval_in),
        .o_best_index    (w_best_index),
        .o_best_uci      (w_best_uci),
        .o_best_eval     (w_best_eval)
    );

    assign am_move_index  = r_index;
    assign am_clear_moves = (r_state == ST_CLEAR);
    assign out_valid      = (r_state == ST_EMIT);
    assign out_index      = r_mode_best ? w_best_index : r_index;
    assign out_uci        = r_mode_best ? w_best_uci : r_uci;
    assign out_eval       = r_mode_best ? w_best_eval : r_eval;
    assign out_last       = out_valid && (r_mode_best || w_is_last);
    assign done           = r_done;
    assign status         = r_status;
    assign busy           = (r_state != ST_IDLE);

endmodule
